// File: rtl/input_frame_deserializer_if.sv
// rtl/input_frame_deserializer_if.sv - word stream handshake into the frame deserializer.
// sof_i exists only when INPUT_DESER_SOF_EN is defined.
interface input_frame_deserializer_if #(
  parameter int WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] word_i;
  logic                  word_valid_i;
  logic                  word_ready_o;
`ifdef INPUT_DESER_SOF_EN
  logic                  sof_i;

  modport master (output word_i, output word_valid_i, output sof_i, input word_ready_o);
  modport slave  (input word_i, input word_valid_i, input sof_i, output word_ready_o);
`else
  modport master (output word_i, output word_valid_i, input word_ready_o);
  modport slave  (input word_i, input word_valid_i, output word_ready_o);
`endif
endinterface

// File: rtl/input_frame_deserializer.sv
// rtl/input_frame_deserializer.sv - word stream to double-buffered wide frame, repeated REPEAT cycles.
// Optional INPUT_DESER_SOF_EN adds sof_i resync on the word stream.
module input_frame_deserializer #(
  parameter int INPUT_WIDTH      = 784,
  parameter int WORD_WIDTH       = 32,
  parameter int REPEAT           = 4,
  parameter int NET_TO_OUT_DELAY = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input_frame_deserializer_if.slave  word_if,
  output logic [INPUT_WIDTH-1:0]     frame_o,
  output logic                       frame_valid_o,
  output logic                       acc_valid_o
);
  localparam int NUM_WORDS  = (INPUT_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int PAD_WIDTH  = NUM_WORDS * WORD_WIDTH;
  localparam int CNT_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int PCNT_W     = $clog2(REPEAT + 1);

  typedef enum logic {FILL, FULL} fill_state_e;

  fill_state_e              state_q, state_d;
  logic [CNT_W-1:0]         wcnt_q, wcnt_d;
  logic [PCNT_W-1:0]        pcnt_q, pcnt_d;
  logic [INPUT_WIDTH-1:0]   shadow_q, shadow_d;
  logic [INPUT_WIDTH-1:0]   frame_q, frame_d;
  logic [PAD_WIDTH-1:0]     shadow_wide;
  logic [CNT_W-1:0]         write_idx;
  logic                     accept;
  logic                     last_word;
  logic                     transfer;

  assign word_if.word_ready_o = (state_q == FILL);
  assign frame_o              = frame_q;
  assign frame_valid_o        = (pcnt_q != '0);

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    pcnt_d      = pcnt_q;
    shadow_d    = shadow_q;
    frame_d     = frame_q;
    shadow_wide = PAD_WIDTH'(shadow_q);
    accept      = word_if.word_valid_i && (state_q == FILL);
`ifdef INPUT_DESER_SOF_EN
    write_idx   = word_if.sof_i ? '0 : wcnt_q;
`else
    write_idx   = wcnt_q;
`endif
    last_word   = (write_idx == CNT_W'(NUM_WORDS - 1));
    // Taking the new frame at pcnt==1 keeps frame_valid_o gap-free across frames.
    transfer    = (state_q == FULL) && (pcnt_q <= PCNT_W'(1));

    if (accept) begin
      shadow_wide[write_idx * WORD_WIDTH +: WORD_WIDTH] = word_if.word_i;
      shadow_d = shadow_wide[INPUT_WIDTH-1:0];
      if (last_word) begin
        wcnt_d  = '0;
        state_d = FULL;
      end else begin
        wcnt_d  = write_idx + CNT_W'(1);
      end
    end

    if (transfer) begin
      frame_d = shadow_q;
      pcnt_d  = PCNT_W'(REPEAT);
      state_d = FILL;
    end else if (pcnt_q != '0) begin
      pcnt_d  = pcnt_q - PCNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= FILL;
      wcnt_q   <= '0;
      pcnt_q   <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      pcnt_q   <= pcnt_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
    end
  end

  // Matches the gate-network latency so the accumulator sees valid with its data.
  generate
    if (NET_TO_OUT_DELAY == 0) begin : g_no_delay
      assign acc_valid_o = frame_valid_o;
    end else begin : g_delay
      logic [NET_TO_OUT_DELAY-1:0] dly_q, dly_d;

      always_comb begin
        dly_d = NET_TO_OUT_DELAY'({dly_q, frame_valid_o});
      end

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          dly_q <= '0;
        end else begin
          dly_q <= dly_d;
        end
      end

      assign acc_valid_o = dly_q[NET_TO_OUT_DELAY-1];
    end
  endgenerate
endmodule

// File: tb/tb_input_frame_deserializer.sv
// tb/tb_input_frame_deserializer.sv - scoreboard bench for input_frame_deserializer.
module tb_input_frame_deserializer;
  localparam int IW = 784;
  localparam int WW = 32;
  localparam int NW = 25;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [IW-1:0] frame, frame32;
  logic          fv, fv32, acc, acc32;
  int            checks = 0;
  int            errors = 0;
  logic [IW-1:0] q[$];
  logic [IW-1:0] q32[$];

  always #5 clk = ~clk;

  input_frame_deserializer_if #(.WORD_WIDTH(WW)) ifc ();
  input_frame_deserializer_if #(.WORD_WIDTH(WW)) ifc32 ();

  input_frame_deserializer u_dut (
    .clk_i(clk), .reset_i(reset), .word_if(ifc),
    .frame_o(frame), .frame_valid_o(fv), .acc_valid_o(acc)
  );

  input_frame_deserializer #(.REPEAT(32)) u_dut32 (
    .clk_i(clk), .reset_i(reset), .word_if(ifc32),
    .frame_o(frame32), .frame_valid_o(fv32), .acc_valid_o(acc32)
  );

  function automatic logic [IW-1:0] build(input logic [WW-1:0] ws[NW]);
    logic [NW*WW-1:0] pad;
    pad = '0;
    for (int n = 0; n < NW; n++) pad[n*WW +: WW] = ws[n];
    return pad[IW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (12) tick();
  endtask

  task automatic send(input logic [WW-1:0] w, input logic s);
    logic took;
    int   guard;
    guard = 0;
    ifc.word_i = w;
    ifc.word_valid_i = 1'b1;
`ifdef INPUT_DESER_SOF_EN
    ifc.sof_i = s;
`endif
    do begin
      took = ifc.word_ready_o;
      tick();
      guard++;
    end while (!took && guard < 200);
    ifc.word_valid_i = 1'b0;
`ifdef INPUT_DESER_SOF_EN
    ifc.sof_i = 1'b0;
`endif
    if (!took) begin
      errors++;
      $display("FAIL send_timeout got ready=%0b want 1 within 200 cycles (s=%0b)", ifc.word_ready_o, s);
    end
  endtask

  task automatic send32(input logic [WW-1:0] w);
    logic took;
    int   guard;
    guard = 0;
    ifc32.word_i = w;
    ifc32.word_valid_i = 1'b1;
    do begin
      took = ifc32.word_ready_o;
      tick();
      guard++;
    end while (!took && guard < 200);
    ifc32.word_valid_i = 1'b0;
    if (!took) begin
      errors++;
      $display("FAIL send32_timeout got ready=%0b want 1 within 200 cycles", ifc32.word_ready_o);
    end
  endtask

  task automatic check_frame(input string name);
    logic [IW-1:0] exp;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s got frame with empty scoreboard want queued frame", name);
    end else begin
      exp = q.pop_front();
      if (frame !== exp) begin
        errors++;
        $display("FAIL %s got %h want %h", name, frame, exp);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks += 4;
    if (ifc.word_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ifc.word_ready_o); end
    if (fv !== 1'b0) begin errors++; $display("FAIL reset_fv got %b want 0", fv); end
    if (acc !== 1'b0) begin errors++; $display("FAIL reset_acc got %b want 0", acc); end
    if (frame !== '0) begin errors++; $display("FAIL reset_frame got %h want 0", frame); end
  endtask

  task automatic test_basic();
    logic [WW-1:0] ws[NW];
    logic          exp_fv, exp_acc;
    for (int n = 0; n < NW; n++) ws[n] = WW'(n);
    q.push_back(build(ws));
    for (int n = 0; n < NW; n++) send(ws[n], 1'b0);
    checks++;
    if (fv !== 1'b0) begin errors++; $display("FAIL basic_fv_at_E got %b want 0", fv); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin
        check_frame("basic_frame");
        checks += 3;
        if (frame[31:0] !== 32'd0) begin errors++; $display("FAIL basic_w0 got %h want 0", frame[31:0]); end
        if (frame[63:32] !== 32'd1) begin errors++; $display("FAIL basic_w1 got %h want 1", frame[63:32]); end
        if (frame[783:768] !== 16'd24) begin errors++; $display("FAIL basic_w24 got %h want 0018", frame[783:768]); end
      end
      exp_fv  = (k <= 4);
      exp_acc = (k >= 3 && k <= 6);
      checks += 2;
      if (fv !== exp_fv) begin errors++; $display("FAIL basic_fv_E+%0d got %b want %b", k, fv, exp_fv); end
      if (acc !== exp_acc) begin errors++; $display("FAIL basic_acc_E+%0d got %b want %b", k, acc, exp_acc); end
    end
    drain();
  endtask

  task automatic test_upper_bits();
    logic [WW-1:0] ws[NW];
    for (int n = 0; n < NW - 1; n++) ws[n] = $urandom();
    ws[NW-1] = 32'hFFFF_0018;
    q.push_back(build(ws));
    for (int n = 0; n < NW; n++) send(ws[n], 1'b0);
    tick();
    check_frame("upper_frame");
    checks++;
    if (frame[783:768] !== 16'h0018) begin errors++; $display("FAIL upper_w24 got %h want 0018", frame[783:768]); end
    drain();
  endtask

  task automatic test_gapped();
    logic [WW-1:0] ws[NW];
    for (int n = 0; n < NW; n++) ws[n] = WW'(n);
    q.push_back(build(ws));
    for (int n = 0; n < NW; n++) begin
      send(ws[n], 1'b0);
      checks++;
      if (fv !== 1'b0) begin errors++; $display("FAIL gapped_fv_early word %0d got %b want 0", n, fv); end
      if (n < NW - 1) tick();
    end
    tick();
    checks++;
    if (fv !== 1'b1) begin errors++; $display("FAIL gapped_fv_rise got %b want 1", fv); end
    check_frame("gapped_frame");
    drain();
  endtask

  task automatic test_reset_mid_fill();
    logic [WW-1:0] ws[NW];
    for (int n = 0; n < 10; n++) send($urandom(), 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks += 3;
    if (ifc.word_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", ifc.word_ready_o); end
    if (fv !== 1'b0) begin errors++; $display("FAIL midrst_fv got %b want 0", fv); end
    if (frame !== '0) begin errors++; $display("FAIL midrst_frame got %h want 0", frame); end
    for (int n = 0; n < NW; n++) ws[n] = 32'hA5A5_A5A5;
    q.push_back(build(ws));
    for (int n = 0; n < NW; n++) begin
      send(ws[n], 1'b0);
      checks++;
      if (fv !== 1'b0) begin errors++; $display("FAIL midrst_fv_early word %0d got %b want 0", n, fv); end
    end
    tick();
    checks++;
    if (fv !== 1'b1) begin errors++; $display("FAIL midrst_fv_rise got %b want 1", fv); end
    check_frame("midrst_frame");
    drain();
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] wa[NW], wb[NW];
    logic [IW-1:0] prev, exp;
    int            guard, run, sw, ready_low;
    for (int n = 0; n < NW; n++) begin
      wa[n] = $urandom();
      wb[n] = $urandom();
    end
    q32.push_back(build(wa));
    q32.push_back(build(wb));
    fork
      begin
        for (int n = 0; n < NW; n++) send32(wa[n]);
        for (int n = 0; n < NW; n++) send32(wb[n]);
      end
      begin
        guard = 0;
        while (!fv32 && guard < 200) begin tick(); guard++; end
        checks++;
        if (!fv32) begin
          errors++;
          $display("FAIL b2b_rise_timeout got fv=%b want 1 within 200 cycles", fv32);
        end else begin
          run = 0;
          sw = -1;
          ready_low = 0;
          prev = frame32;
          exp = (q32.size() != 0) ? q32.pop_front() : '0;
          if (frame32 !== exp) begin errors++; $display("FAIL b2b_frame_a got %h want %h", frame32, exp); end
          while (fv32 && run < 300) begin
            if (frame32 !== prev) begin
              if (sw < 0) sw = run;
              exp = (q32.size() != 0) ? q32.pop_front() : '0;
              checks++;
              if (frame32 !== exp) begin errors++; $display("FAIL b2b_frame_b got %h want %h", frame32, exp); end
            end
            if (!ifc32.word_ready_o) ready_low++;
            prev = frame32;
            run++;
            tick();
          end
          checks += 4;
          if (run !== 64) begin errors++; $display("FAIL b2b_run got %0d want 64", run); end
          if (sw !== 32) begin errors++; $display("FAIL b2b_switch got %0d want 32", sw); end
          if (ready_low !== 7) begin errors++; $display("FAIL b2b_stall got %0d want 7", ready_low); end
          if (q32.size() !== 0) begin errors++; $display("FAIL b2b_leftover got %0d want 0", q32.size()); end
        end
      end
    join
    drain();
  endtask

`ifdef INPUT_DESER_SOF_EN
  task automatic test_sof();
    logic [WW-1:0] ws[NW];
    int            frames;
    logic          prev_fv;
    for (int n = 0; n < 7; n++) send($urandom(), 1'b0);
    for (int n = 0; n < NW; n++) ws[n] = $urandom();
    q.push_back(build(ws));
    send(ws[0], 1'b1);
    for (int n = 1; n < NW; n++) send(ws[n], 1'b0);
    frames = 0;
    prev_fv = fv;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (fv && !prev_fv) begin
        frames++;
        check_frame("sof_frame");
        checks++;
        if (frame[31:0] !== ws[0]) begin errors++; $display("FAIL sof_w0 got %h want %h", frame[31:0], ws[0]); end
      end
      prev_fv = fv;
    end
    checks++;
    if (frames !== 1) begin errors++; $display("FAIL sof_frames got %0d want 1", frames); end
    drain();
  endtask
`endif

  initial begin
    ifc.word_i = '0;
    ifc.word_valid_i = 1'b0;
    ifc32.word_i = '0;
    ifc32.word_valid_i = 1'b0;
`ifdef INPUT_DESER_SOF_EN
    ifc.sof_i = 1'b0;
    ifc32.sof_i = 1'b0;
`endif
    #1;
    test_reset();
    test_basic();
    test_upper_bits();
    test_gapped();
    test_reset_mid_fill();
    test_back_to_back();
`ifdef INPUT_DESER_SOF_EN
    test_sof();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/input_frame_deserializer.md
Name: input_frame_deserializer

Overview:
- Upstream stage of the output accumulator/classifier.
- Assembles a binarized input frame from a narrow word stream into a double-buffered wide register that drives the logic-gate network input.
- Presents each frame REPEAT consecutive cycles so the downstream moving average accumulates over repeats.
- Generates the network-latency-aligned valid that the accumulator consumes as its input valid.

Parameters:
- INPUT_WIDTH, 784, frame size in bits (network input width).
- WORD_WIDTH, 32, input stream word width in bits.
- REPEAT, 4, cycles each frame is presented; legal range >= 1.
- NET_TO_OUT_DELAY, 2, pipeline latency of the gate network in cycles; delay applied to acc_valid_o; 0 allowed.
- Derived: NUM_WORDS = ceil(INPUT_WIDTH/WORD_WIDTH), 25 at defaults.

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- reset_i  in  1  reset; synchronous, active-high.
- word_i  in  WORD_WIDTH  input data word.
- word_valid_i  in  1  word_i valid.
- word_ready_o  out  1  block can accept a word.
- frame_o  out  INPUT_WIDTH  frame presented to the network.
- frame_valid_o  out  1  frame_o valid this cycle.
- acc_valid_o  out  1  frame_valid_o delayed by NET_TO_OUT_DELAY cycles; drives the accumulator input valid.

Behaviour:
- Handshake: a word is accepted on an edge where word_valid_i && word_ready_o.
  - word_ready_o = !shadow_full; it is combinational from the register only and never depends on word_valid_i.
- Fill:
  - Accepted word n (0..NUM_WORDS-1) is written to shadow bits [n*WORD_WIDTH +: WORD_WIDTH].
  - Bits of the last word at or above INPUT_WIDTH are discarded.
  - The word counter increments per accepted word.
  - On acceptance of word NUM_WORDS-1: counter wraps to 0 and shadow_full is set at that edge.
- Presentation counter pcnt, width clog2(REPEAT+1):
  - frame_valid_o = (pcnt != 0).
  - pcnt decrements each cycle while nonzero.
- Transfer:
  - Occurs on an edge where shadow_full==1 && (pcnt==0 || pcnt==1).
  - On that edge: frame_o <= shadow, pcnt <= REPEAT, shadow_full <= 0.
  - Timing: last word accepted at edge E gives transfer at E+1; frame_valid_o is high after edges E+1..E+REPEAT.
  - A back-to-back transfer when pcnt==1 keeps frame_valid_o continuously high, with frame_o changing at that edge.
- Stall: while shadow_full and pcnt>1, word_ready_o=0 and no word is accepted. No input word is ever dropped or overwritten.
- Hold: frame_o changes only on transfer or reset; it holds the last frame while frame_valid_o is 0.
- Valid alignment: acc_valid_o comes from a NET_TO_OUT_DELAY-deep shift register of frame_valid_o, so acc_valid_o(t) = frame_valid_o(t-NET_TO_OUT_DELAY). For delay 0 it is a direct wire.
- FSM for fill side:
  - FILL: shadow_full=0, ready=1. Goes to FULL on the last-word accept.
  - FULL: ready=0. Goes to FILL on transfer.
  - Presentation side: IDLE (pcnt==0) / PRESENT (pcnt!=0).
- Simultaneous events: a last-word accept and a transfer cannot coincide, because ready=0 in FULL.
- Reset (any cycle, including mid-fill or mid-presentation), at the next edge:
  - counters cleared, shadow_full=0, shadow cleared to 0;
  - frame_o=0, frame_valid_o=0, acc_valid_o=0, delay line cleared;
  - word_ready_o=1 after reset.

Optional Feature:
- Macro INPUT_DESER_SOF_EN.
- Defined: adds input port sof_i (1 bit, qualified by an accepted word).
  - An accepted word with sof_i=1 is written at index 0 and the counter becomes 1, discarding any partial frame (resync).
  - With NUM_WORDS==1 it completes the frame immediately.
- Undefined: no sof_i port; frame boundaries come only from the word count.

Test Plan:
- Defaults, 25 words on consecutive cycles (word n = n) -> frame_valid_o=1 after edges E+1..E+4; frame_o[31:0]=0, frame_o[63:32]=1, frame_o[783:768]=24[15:0]; acc_valid_o=1 after edges E+3..E+6.
- Last word 0xFFFF_0018 -> frame_o[783:768]=0x0018; no upper bits are stored anywhere.
- REPEAT=32, two frames back-to-back -> word_ready_o=0 from frame-2 completion until the pcnt==1 edge; frame_valid_o high for 64 contiguous cycles; frame_o switches exactly at cycle 32.
- word_valid_i toggled every other cycle over 50 cycles -> identical frame_o contents to the first test; frame_valid_o rises after the 25th accept.
- reset_i pulsed after 10 accepted words, then 25 new words of 0xA5A5A5A5 -> frame_o equals only the new data; no frame_valid_o from the aborted fill.
- INPUT_DESER_SOF_EN: 7 words, then a sof_i word plus 24 words -> exactly one frame, whose word 0 is the sof_i word.
